writeback_stage: RTL and testbench



---
 rtl/writeback_stage_if.sv | 27 ++
 rtl/writeback_stage.sv | 183 ++++++++++++++++++
 tb/tb_writeback_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Memory-to-writeback instruction bundle.
// master = memory stage, slave = writeback stage.
interface writeback_stage_if;
  logic        valid_in;
  logic [31:0] pc;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;
  logic        csr_write;
  logic [11:0] csr_address;
  logic [31:0] csr_data;
  logic        mret_in;
  logic        wfi_in;
  logic        exception;
  logic [3:0]  exception_cause;

  modport master (
    output valid_in, pc, rd_address, rd_data,
    output csr_write, csr_address, csr_data,
    output mret_in, wfi_in, exception, exception_cause
  );

  modport slave (
    input valid_in, pc, rd_address, rd_data,
    input csr_write, csr_address, csr_data,
    input mret_in, wfi_in, exception, exception_cause
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback: commit, trap decision, redirect and wrong-path flush.
// Define WB_WFI_EN to enable the wfi SLEEP state.
module writeback_stage #(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [31:0] RESET_ECP    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  writeback_stage_if.slave mem,
  input  logic        eip,
  input  logic        tip,
  input  logic        sip,
  output logic        reg_write_enable,
  output logic [4:0]  reg_write_address,
  output logic [31:0] reg_write_data,
  output logic        csr_write_enable,
  output logic [11:0] csr_write_address,
  output logic [31:0] csr_write_data,
  output logic        retired,
  output logic        traped,
  output logic        mret,
  output logic [31:0] ecp,
  output logic [31:0] cause,
  output logic        redirect,
  output logic        redirect_to_trap,
  output logic        stall
);

  logic        rwe_q, rwe_d, cwe_q, cwe_d;
  logic [4:0]  rwa_q, rwa_d;
  logic [31:0] rwd_q, rwd_d, cwd_q, cwd_d;
  logic [11:0] cwa_q, cwa_d;
  logic        ret_q, ret_d, trp_q, trp_d;
  logic        mret_q, mret_d, redir_q, redir_d;
  logic        rtt_q, rtt_d;
  logic [31:0] ecp_q, ecp_d, cause_q, cause_d;
  logic [3:0]  flush_q, flush_d;
  logic        run, accept, irq, wfi_go;
  logic [3:0]  irq_code;

  assign irq      = eip | tip | sip;
  assign irq_code = eip ? 4'd11 : (sip ? 4'd3 : 4'd7);
  assign accept   = mem.valid_in & run & (flush_q == 4'd0);

`ifdef WB_WFI_EN
  typedef enum logic {RUN, SLEEP} state_e;
  state_e state_q, state_d;
  logic   stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= (state_d == SLEEP);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (wfi_go) state_d = SLEEP;
      SLEEP:   if (irq) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign run   = (state_q == RUN);
  assign stall = stall_q;
`else
  logic unused_wfi;
  assign unused_wfi = ^{mem.wfi_in, wfi_go};
  assign run   = 1'b1;
  assign stall = 1'b0;
`endif

  always_comb begin
    rwe_d   = 1'b0;
    cwe_d   = 1'b0;
    ret_d   = 1'b0;
    trp_d   = 1'b0;
    mret_d  = 1'b0;
    redir_d = 1'b0;
    rtt_d   = 1'b0;
    wfi_go  = 1'b0;
    rwa_d   = rwa_q;
    rwd_d   = rwd_q;
    cwa_d   = cwa_q;
    cwd_d   = cwd_q;
    ecp_d   = ecp_q;
    cause_d = cause_q;
    if (accept) begin
      rwa_d = mem.rd_address;
      rwd_d = mem.rd_data;
      cwa_d = mem.csr_address;
      cwd_d = mem.csr_data;
      // Overlapping conditions: first match wins.
      priority case (1'b1)
        irq: begin
          trp_d   = 1'b1;
          redir_d = 1'b1;
          rtt_d   = 1'b1;
          ecp_d   = mem.pc;
          cause_d = {1'b1, 27'b0, irq_code};
        end
        mem.exception: begin
          trp_d   = 1'b1;
          redir_d = 1'b1;
          rtt_d   = 1'b1;
          ecp_d   = mem.pc;
          cause_d = {28'b0, mem.exception_cause};
        end
        mem.mret_in: begin
          mret_d  = 1'b1;
          ret_d   = 1'b1;
          redir_d = 1'b1;
        end
        default: begin
          ret_d  = 1'b1;
          rwe_d  = (mem.rd_address != 5'd0);
          cwe_d  = mem.csr_write;
          wfi_go = mem.wfi_in;
        end
      endcase
    end
    if (redir_d)
      flush_d = 4'(FLUSH_CYCLES);
    else if (flush_q != 4'd0)
      flush_d = flush_q - 4'd1;
    else
      flush_d = 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rwe_q   <= 1'b0;
      rwa_q   <= '0;
      rwd_q   <= '0;
      cwe_q   <= 1'b0;
      cwa_q   <= '0;
      cwd_q   <= '0;
      ret_q   <= 1'b0;
      trp_q   <= 1'b0;
      mret_q  <= 1'b0;
      redir_q <= 1'b0;
      rtt_q   <= 1'b0;
      ecp_q   <= RESET_ECP;
      cause_q <= RESET_ECP;
      flush_q <= 4'd0;
    end else begin
      rwe_q   <= rwe_d;
      rwa_q   <= rwa_d;
      rwd_q   <= rwd_d;
      cwe_q   <= cwe_d;
      cwa_q   <= cwa_d;
      cwd_q   <= cwd_d;
      ret_q   <= ret_d;
      trp_q   <= trp_d;
      mret_q  <= mret_d;
      redir_q <= redir_d;
      rtt_q   <= rtt_d;
      ecp_q   <= ecp_d;
      cause_q <= cause_d;
      flush_q <= flush_d;
    end
  end

  assign reg_write_enable  = rwe_q;
  assign reg_write_address = rwa_q;
  assign reg_write_data    = rwd_q;
  assign csr_write_enable  = cwe_q;
  assign csr_write_address = cwa_q;
  assign csr_write_data    = cwd_q;
  assign retired           = ret_q;
  assign traped            = trp_q;
  assign mret              = mret_q;
  assign ecp               = ecp_q;
  assign cause             = cause_q;
  assign redirect          = redir_q;
  assign redirect_to_trap  = rtt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a cycle-level reference model.
// Covers the WB_WFI_EN build as well as the default build.
module tb_writeback_stage;
  localparam int FC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_stage_if mi();
  logic eip, tip, sip;
  logic        rwe, cwe, ret, trp, mrt, rdr, rtt, stl;
  logic [4:0]  rwa;
  logic [31:0] rwd, cwd, ecp, cse;
  logic [11:0] cwa;

  writeback_stage #(.FLUSH_CYCLES(FC), .RESET_ECP(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mi),
    .eip(eip), .tip(tip), .sip(sip),
    .reg_write_enable(rwe), .reg_write_address(rwa),
    .reg_write_data(rwd),
    .csr_write_enable(cwe), .csr_write_address(cwa),
    .csr_write_data(cwd),
    .retired(ret), .traped(trp), .mret(mrt),
    .ecp(ecp), .cause(cse),
    .redirect(rdr), .redirect_to_trap(rtt), .stall(stl)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a redirect at edge N squashes edges N+1..N+FC.
  int cyc = 0;
  int last_redir = -100;
  bit m_sleep = 0;
  bit m_irq, m_acc;
  logic        e_rwe, e_cwe, e_ret, e_trp, e_mrt, e_rdr, e_rtt, e_stl;
  logic [4:0]  e_rwa;
  logic [31:0] e_rwd, e_cwd, e_ecp, e_cse;
  logic [11:0] e_cwa;

  task automatic m_trap(input logic [31:0] p, input logic [31:0] c);
    e_trp = 1; e_rdr = 1; e_rtt = 1;
    e_ecp = p; e_cse = c;
    last_redir = cyc;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; last_redir = -100; m_sleep = 0;
      e_rwe = 0; e_cwe = 0; e_ret = 0; e_trp = 0;
      e_mrt = 0; e_rdr = 0; e_rtt = 0; e_stl = 0;
      e_rwa = 0; e_rwd = 0; e_cwa = 0; e_cwd = 0;
      e_ecp = 0; e_cse = 0;
    end else begin
      cyc++;
      m_irq = eip | tip | sip;
      m_acc = mi.valid_in && !m_sleep && (cyc > last_redir + FC);
      e_rwe = 0; e_cwe = 0; e_ret = 0; e_trp = 0;
      e_mrt = 0; e_rdr = 0; e_rtt = 0;
`ifdef WB_WFI_EN
      if (m_sleep && m_irq) m_sleep = 0;
`endif
      if (m_acc) begin
        e_rwa = mi.rd_address; e_rwd = mi.rd_data;
        e_cwa = mi.csr_address; e_cwd = mi.csr_data;
        if (m_irq)
          m_trap(mi.pc, eip ? 32'h8000000B :
                        (sip ? 32'h80000003 : 32'h80000007));
        else if (mi.exception)
          m_trap(mi.pc, {28'b0, mi.exception_cause});
        else if (mi.mret_in) begin
          e_mrt = 1; e_ret = 1; e_rdr = 1; e_rtt = 0;
          last_redir = cyc;
        end else begin
          e_ret = 1;
          e_rwe = (mi.rd_address != 0);
          e_cwe = mi.csr_write;
`ifdef WB_WFI_EN
          if (mi.wfi_in) m_sleep = 1;
`endif
        end
      end
      e_stl = m_sleep;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("retired", 32'(ret), 32'(e_ret));
      chk("traped", 32'(trp), 32'(e_trp));
      chk("mret", 32'(mrt), 32'(e_mrt));
      chk("redirect", 32'(rdr), 32'(e_rdr));
      chk("redirect_to_trap", 32'(rtt), 32'(e_rtt));
      chk("stall", 32'(stl), 32'(e_stl));
      chk("ecp", ecp, e_ecp);
      chk("cause", cse, e_cse);
      chk("reg_we", 32'(rwe), 32'(e_rwe));
      chk("csr_we", 32'(cwe), 32'(e_cwe));
      if (e_rwe) begin
        chk("reg_addr", 32'(rwa), 32'(e_rwa));
        chk("reg_data", rwd, e_rwd);
      end
      if (e_cwe) begin
        chk("csr_addr", 32'(cwa), 32'(e_cwa));
        chk("csr_data", cwd, e_cwd);
      end
    end
  end

  task automatic clr_in();
    mi.valid_in = 0; mi.pc = 0; mi.rd_address = 0; mi.rd_data = 0;
    mi.csr_write = 0; mi.csr_address = 0; mi.csr_data = 0;
    mi.mret_in = 0; mi.wfi_in = 0; mi.exception = 0;
    mi.exception_cause = 0;
    eip = 0; tip = 0; sip = 0;
  endtask

  task automatic inst(input logic [31:0] p, input logic [4:0] rd,
                      input logic [31:0] d);
    clr_in();
    mi.valid_in = 1; mi.pc = p; mi.rd_address = rd; mi.rd_data = d;
  endtask

  task automatic cyc1();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    repeat (2) @(negedge clk);
    chk("rst retired", 32'(ret), 0);
    chk("rst redirect", 32'(rdr), 0);
    chk("rst ecp", ecp, 0);
    chk("rst cause", cse, 0);
    chk("rst stall", 32'(stl), 0);
    rst_n = 1;

    inst(32'h100, 5, 32'hDEAD); cyc1();
    chk("t1 rwe", 32'(rwe), 1);
    chk("t1 rwa", 32'(rwa), 5);
    chk("t1 rwd", rwd, 32'hDEAD);
    chk("t1 ret", 32'(ret), 1);

    inst(32'h104, 0, 32'h1); cyc1();
    chk("t2 rwe", 32'(rwe), 0);
    chk("t2 ret", 32'(ret), 1);

    inst(32'h108, 0, 0);
    mi.csr_write = 1; mi.csr_address = 12'h340; mi.csr_data = 32'h1234;
    cyc1();
    chk("t3 cwe", 32'(cwe), 1);
    chk("t3 cwa", 32'(cwa), 32'h340);
    chk("t3 cwd", cwd, 32'h1234);
    chk("t3 ret", 32'(ret), 1);

    inst(32'h200, 3, 32'h5);
    mi.exception = 1; mi.exception_cause = 4'd11;
    cyc1();
    chk("exc traped", 32'(trp), 1);
    chk("exc ecp", ecp, 32'h200);
    chk("exc cause", cse, 32'h0000000B);
    chk("exc redirect", 32'(rdr), 1);
    chk("exc to_trap", 32'(rtt), 1);
    chk("exc rwe", 32'(rwe), 0);
    chk("exc ret", 32'(ret), 0);
    for (int i = 0; i < FC; i++) begin
      inst(32'h204 + 4 * i, 1, 32'h9); cyc1();
      chk("flush ret", 32'(ret), 0);
      chk("flush rwe", 32'(rwe), 0);
    end
    inst(32'h210, 1, 32'h9); cyc1();
    chk("post flush ret", 32'(ret), 1);

    inst(32'h300, 0, 0); mi.mret_in = 1; eip = 1; tip = 1; cyc1();
    chk("irq mret traped", 32'(trp), 1);
    chk("irq mret cause", cse, 32'h8000000B);
    chk("irq mret ecp", ecp, 32'h300);
    chk("irq mret mret", 32'(mrt), 0);
    clr_in(); repeat (FC) cyc1();

    inst(32'h300, 0, 0); mi.mret_in = 1; cyc1();
    chk("mret mret", 32'(mrt), 1);
    chk("mret ret", 32'(ret), 1);
    chk("mret redirect", 32'(rdr), 1);
    chk("mret to_trap", 32'(rtt), 0);
    clr_in(); repeat (FC) cyc1();

    inst(32'h310, 0, 0); sip = 1; tip = 1; cyc1();
    chk("sip cause", cse, 32'h80000003);
    clr_in(); repeat (FC) cyc1();

    inst(32'h500, 2, 32'h1);
    mi.exception = 1; mi.exception_cause = 4'd2;
    cyc1();
    chk("pre-rst traped", 32'(trp), 1);
    clr_in();
    #2 rst_n = 0;
    #1;
    chk("arst traped", 32'(trp), 0);
    chk("arst redirect", 32'(rdr), 0);
    chk("arst ecp", ecp, 0);
    chk("arst cause", cse, 0);
    @(negedge clk);
    rst_n = 1;
    inst(32'h600, 7, 32'h77); cyc1();
    chk("post-rst ret", 32'(ret), 1);
    chk("post-rst rwe", 32'(rwe), 1);

    inst(32'h400, 0, 0); mi.wfi_in = 1; cyc1();
    chk("wfi ret", 32'(ret), 1);
`ifdef WB_WFI_EN
    chk("wfi stall", 32'(stl), 1);
`else
    chk("wfi stall", 32'(stl), 0);
`endif
    for (int i = 0; i < 10; i++) begin
      inst(32'h404 + 4 * i, 2, 32'h3); cyc1();
`ifdef WB_WFI_EN
      chk("sleep ret", 32'(ret), 0);
`else
      chk("nop wfi ret", 32'(ret), 1);
`endif
    end
    clr_in(); tip = 1; cyc1();
    chk("wake stall", 32'(stl), 0);
    inst(32'h440, 0, 0); tip = 1; cyc1();
    chk("wake traped", 32'(trp), 1);
    chk("wake cause", cse, 32'h80000007);
    chk("wake ecp", ecp, 32'h440);
    clr_in(); repeat (FC + 1) cyc1();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
